// File: rtl/ysyx_22050598_axi_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single AXI4 master, one transaction in flight.
// Define YSYX_22050598_ARB_RR_EN for round-robin grant; otherwise load/store has fixed priority.
module ysyx_22050598_axi_arbiter (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_req_addr,
  output logic        if_resp_valid,
  output logic [63:0] if_resp_data,

  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic        ls_req_we,
  input  logic [2:0]  ls_req_size,
  input  logic [63:0] ls_req_addr,
  input  logic [63:0] ls_req_wdata,
  input  logic [7:0]  ls_req_wstrb,
  output logic        ls_resp_valid,
  output logic [63:0] ls_resp_data,

  output logic [3:0]  M_AXI_AWID,
  output logic [63:0] M_AXI_AWADDR,
  output logic [7:0]  M_AXI_AWLEN,
  output logic [2:0]  M_AXI_AWSIZE,
  output logic [1:0]  M_AXI_AWBURST,
  output logic [3:0]  M_AXI_AWCACHE,
  output logic [2:0]  M_AXI_AWPROT,
  output logic [3:0]  M_AXI_AWQOS,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,

  output logic [63:0] M_AXI_WDATA,
  output logic [7:0]  M_AXI_WSTRB,
  output logic        M_AXI_WLAST,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,

  input  logic        M_AXI_BVALID,
  input  logic [1:0]  M_AXI_BRESP,
  output logic        M_AXI_BREADY,

  output logic [3:0]  M_AXI_ARID,
  output logic [63:0] M_AXI_ARADDR,
  output logic [7:0]  M_AXI_ARLEN,
  output logic [2:0]  M_AXI_ARSIZE,
  output logic [1:0]  M_AXI_ARBURST,
  output logic [3:0]  M_AXI_ARCACHE,
  output logic [2:0]  M_AXI_ARPROT,
  output logic [3:0]  M_AXI_ARQOS,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,

  input  logic [63:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RLAST,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] AR   = 3'd1;
  localparam logic [2:0] R    = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] B    = 3'd4;

  localparam logic [2:0] FETCH_SIZE = 3'b010;

  logic [2:0]  state_q, state_d;
  logic        owner_q;
  logic [63:0] addr_q;
  logic [2:0]  size_q;
  logic [63:0] wdata_q;
  logic [7:0]  wstrb_q;
  logic        awDone_q, wDone_q;
  logic        ifRespValid_q, lsRespValid_q;
  logic [63:0] ifRespData_q, lsRespData_q;

  logic idle, lsGrant, ifGrant, accept;
  logic awHs, wHs, awFinish, wFinish, rDone, bDone;

  // Response codes carry no information the requesters can use.
  logic unusedResp;
  assign unusedResp = ^{M_AXI_BRESP, M_AXI_RRESP};

  // Ready is suppressed while reset is held so nothing is accepted during reset.
  assign idle = (state_q == IDLE) && !rst;

`ifdef YSYX_22050598_ARB_RR_EN
  logic lsPrio_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lsPrio_q <= 1'b1;
    end else if (accept) begin
      lsPrio_q <= if_req_ready;
    end
  end

  always_comb begin
    lsGrant = ls_req_valid && (lsPrio_q || !if_req_valid);
  end
`else
  always_comb begin
    lsGrant = ls_req_valid;
  end
`endif

  assign ifGrant      = if_req_valid && !lsGrant;
  assign ls_req_ready = idle && lsGrant;
  assign if_req_ready = idle && ifGrant;
  assign accept       = ls_req_ready || if_req_ready;

  assign awHs     = M_AXI_AWVALID && M_AXI_AWREADY;
  assign wHs      = M_AXI_WVALID && M_AXI_WREADY;
  assign awFinish = awDone_q || awHs;
  assign wFinish  = wDone_q || wHs;
  assign rDone    = (state_q == R) && M_AXI_RVALID && M_AXI_RLAST;
  assign bDone    = (state_q == B) && M_AXI_BVALID;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (ls_req_ready && ls_req_we) ? WR : AR;
      AR:   if (M_AXI_ARREADY) state_d = R;
      R:    if (rDone) state_d = IDLE;
      WR:   if (awFinish && wFinish) state_d = B;
      B:    if (bDone) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      awDone_q <= 1'b0;
      wDone_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q != WR) begin
        awDone_q <= 1'b0;
        wDone_q  <= 1'b0;
      end else begin
        if (awHs) awDone_q <= 1'b1;
        if (wHs)  wDone_q  <= 1'b1;
      end
    end
  end

  // Request capture: the AXI address/data channels are driven only from these copies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (accept) begin
      owner_q <= ls_req_ready;
      addr_q  <= ls_req_ready ? ls_req_addr : if_req_addr;
      size_q  <= ls_req_ready ? ls_req_size : FETCH_SIZE;
      wdata_q <= ls_req_ready ? ls_req_wdata : '0;
      wstrb_q <= ls_req_ready ? ls_req_wstrb : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifRespValid_q <= 1'b0;
      lsRespValid_q <= 1'b0;
      ifRespData_q  <= '0;
      lsRespData_q  <= '0;
    end else begin
      ifRespValid_q <= 1'b0;
      lsRespValid_q <= 1'b0;
      if (rDone) begin
        if (owner_q) begin
          lsRespValid_q <= 1'b1;
          lsRespData_q  <= M_AXI_RDATA;
        end else begin
          ifRespValid_q <= 1'b1;
          ifRespData_q  <= M_AXI_RDATA;
        end
      end else if (bDone) begin
        lsRespValid_q <= 1'b1;
        lsRespData_q  <= '0;
      end
    end
  end

  assign if_resp_valid = ifRespValid_q;
  assign if_resp_data  = ifRespData_q;
  assign ls_resp_valid = lsRespValid_q;
  assign ls_resp_data  = lsRespData_q;

  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWLEN   = '0;
  assign M_AXI_AWSIZE  = size_q;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWCACHE = '0;
  assign M_AXI_AWPROT  = '0;
  assign M_AXI_AWQOS   = '0;
  assign M_AXI_AWVALID = (state_q == WR) && !awDone_q;

  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WLAST   = 1'b1;
  assign M_AXI_WVALID  = (state_q == WR) && !wDone_q;

  assign M_AXI_BREADY  = (state_q == B);

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARLEN   = '0;
  assign M_AXI_ARSIZE  = size_q;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARCACHE = '0;
  assign M_AXI_ARPROT  = '0;
  assign M_AXI_ARQOS   = '0;
  assign M_AXI_ARVALID = (state_q == AR);

  assign M_AXI_RREADY  = (state_q == R);

endmodule

// File: tb/tb_ysyx_22050598_axi_arbiter.sv
// Directed bench for the fetch/load-store AXI arbiter; the AXI slave is driven step by step.
// Expectations for simultaneous requests follow YSYX_22050598_ARB_RR_EN when defined.
module tb_ysyx_22050598_axi_arbiter;

`ifdef YSYX_22050598_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk, rst;
  logic        if_req_valid, if_req_ready;
  logic [63:0] if_req_addr;
  logic        if_resp_valid;
  logic [63:0] if_resp_data;
  logic        ls_req_valid, ls_req_ready, ls_req_we;
  logic [2:0]  ls_req_size;
  logic [63:0] ls_req_addr, ls_req_wdata;
  logic [7:0]  ls_req_wstrb;
  logic        ls_resp_valid;
  logic [63:0] ls_resp_data;
  logic [3:0]  awid, arid, awcache, arcache, awqos, arqos;
  logic [63:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  int checks = 0;
  int fails  = 0;

  ysyx_22050598_axi_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_we(ls_req_we),
    .ls_req_size(ls_req_size), .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata),
    .ls_req_wstrb(ls_req_wstrb), .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWCACHE(awcache), .M_AXI_AWPROT(awprot),
    .M_AXI_AWQOS(awqos), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready), .M_AXI_BVALID(bvalid), .M_AXI_BRESP(bresp), .M_AXI_BREADY(bready),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARCACHE(arcache), .M_AXI_ARPROT(arprot),
    .M_AXI_ARQOS(arqos), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ifV, input logic [63:0] ifA, input logic lsV,
                               input logic lsWe, input logic [2:0] lsSz, input logic [63:0] lsA);
    if_req_valid = ifV;
    if_req_addr  = ifA;
    ls_req_valid = lsV;
    ls_req_we    = lsWe;
    ls_req_size  = lsSz;
    ls_req_addr  = lsA;
  endtask

  // Called at the negedge before the accepting posedge with ARREADY high; returns at the
  // negedge of the cycle where the response pulse is expected.
  task automatic readTxn(input logic [63:0] expAddr, input logic [2:0] expSize,
                         input logic [63:0] data, input bit dropLs, input bit dropIf);
    @(negedge clk);
    if (dropLs) ls_req_valid = 1'b0;
    if (dropIf) if_req_valid = 1'b0;
    #1;
    checkOutput("arvalid", {63'd0, arvalid}, 64'd1);
    checkOutput("araddr", araddr, expAddr);
    checkOutput("arsize", {61'd0, arsize}, {61'd0, expSize});
    checkOutput("ready in AR", {62'd0, if_req_ready, ls_req_ready}, 64'd0);
    @(negedge clk);
    checkOutput("rready", {63'd0, rready}, 64'd1);
    checkOutput("arvalid in R", {63'd0, arvalid}, 64'd0);
    rvalid = 1'b1; rlast = 1'b1; rdata = data; rresp = 2'b10;
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0, 3'd0, 64'd0);
    ls_req_wdata = '0; ls_req_wstrb = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rlast = 0; rdata = '0; rresp = 0;

    repeat (2) @(negedge clk);
    checkOutput("reset valids", {58'd0, arvalid, awvalid, wvalid, bready, rready, if_resp_valid}, 64'd0);
    checkOutput("reset resp data", if_resp_data | ls_resp_data, 64'd0);
    checkOutput("tieoff burst/wlast", {59'd0, arburst, awburst, wlast}, {59'd0, 2'b01, 2'b01, 1'b1});
    rst = 1'b0;

    // Zero-wait fetch: ARVALID in cycle 1, response pulse in cycle 3.
    arready = 1'b1;
    applyStimulus(1'b1, 64'h8000_0000, 1'b0, 1'b0, 3'd0, 64'd0);
    #1 checkOutput("fetch if ready", {63'd0, if_req_ready}, 64'd1);
    readTxn(64'h8000_0000, 3'd2, 64'h0000_0013_0000_0297, 1'b0, 1'b1);
    checkOutput("fetch resp valid", {63'd0, if_resp_valid}, 64'd1);
    checkOutput("fetch resp data", if_resp_data, 64'h0000_0013_0000_0297);
    @(negedge clk);
    checkOutput("fetch pulse width", {63'd0, if_resp_valid}, 64'd0);

    // Simultaneous requests, twice.
    applyStimulus(1'b1, 64'h200, 1'b1, 1'b0, 3'd3, 64'h100);
    #1 checkOutput("simul first grant", {62'd0, if_req_ready, ls_req_ready}, 64'd1);
    readTxn(64'h100, 3'd3, 64'h1111, 1'b0, 1'b0);
    checkOutput("simul first ls resp", {63'd0, ls_resp_valid}, 64'd1);
    checkOutput("simul first data", ls_resp_data, 64'h1111);
    checkOutput("simul second grant", {62'd0, if_req_ready, ls_req_ready}, RR ? 64'd2 : 64'd1);
    readTxn(RR ? 64'h200 : 64'h100, RR ? 3'd2 : 3'd3, 64'h2222, 1'b1, 1'b0);
    checkOutput("simul second owner", {62'd0, if_resp_valid, ls_resp_valid}, RR ? 64'd2 : 64'd1);
    checkOutput("simul second data", RR ? if_resp_data : ls_resp_data, 64'h2222);
    checkOutput("simul if after ls drop", {62'd0, if_req_ready, ls_req_ready}, 64'd2);
    readTxn(64'h200, 3'd2, 64'h3333, 1'b0, 1'b1);
    checkOutput("simul third if resp", {62'd0, if_resp_valid, ls_resp_valid}, 64'd2);
    checkOutput("simul third data", if_resp_data, 64'h3333);

    // Store with AWREADY two cycles after WREADY.
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b1, 3'd3, 64'h8000_1000);
    ls_req_wdata = 64'hDEAD_BEEF; ls_req_wstrb = 8'h0F;
    #1 checkOutput("store ls ready", {63'd0, ls_req_ready}, 64'd1);
    @(negedge clk);
    ls_req_valid = 1'b0;
    checkOutput("store aw+w valid", {62'd0, awvalid, wvalid}, 64'd3);
    checkOutput("store awaddr", awaddr, 64'h8000_1000);
    checkOutput("store awsize", {61'd0, awsize}, 64'd3);
    checkOutput("store wdata", wdata, 64'hDEAD_BEEF);
    checkOutput("store wstrb", {56'd0, wstrb}, 64'h0F);
    wready = 1'b1;
    @(negedge clk);
    wready = 1'b0;
    checkOutput("store w dropped", {62'd0, awvalid, wvalid}, 64'd2);
    @(negedge clk);
    checkOutput("store aw still", {62'd0, awvalid, bready}, 64'd2);
    awready = 1'b1;
    @(negedge clk);
    awready = 1'b0;
    checkOutput("store in B", {61'd0, awvalid, bready, ls_resp_valid}, 64'd2);
    bvalid = 1'b1; bresp = 2'b10;
    @(negedge clk);
    bvalid = 1'b0; bresp = 2'b00;
    checkOutput("store resp valid", {62'd0, ls_resp_valid, bready}, 64'd2);
    checkOutput("store resp data", ls_resp_data, 64'd0);
    @(negedge clk);
    checkOutput("store pulse width", {63'd0, ls_resp_valid}, 64'd0);

    // ARREADY held low: address stable, waiting LS request not accepted.
    arready = 1'b0;
    applyStimulus(1'b1, 64'h8000_0040, 1'b0, 1'b0, 3'd0, 64'd0);
    #1 checkOutput("stall if ready", {63'd0, if_req_ready}, 64'd1);
    @(negedge clk);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b0, 3'd3, 64'h300);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checkOutput("stall arvalid", {63'd0, arvalid}, 64'd1);
      checkOutput("stall araddr", araddr, 64'h8000_0040);
      checkOutput("stall no ready", {62'd0, if_req_ready, ls_req_ready}, 64'd0);
    end
    arready = 1'b1;
    @(negedge clk);
    checkOutput("stall rready", {63'd0, rready}, 64'd1);
    rvalid = 1'b1; rlast = 1'b1; rdata = 64'h4444;
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0;
    checkOutput("stall if resp", {62'd0, if_resp_valid, ls_resp_valid}, 64'd2);
    checkOutput("stall if data", if_resp_data, 64'h4444);
    checkOutput("waiting ls granted", {63'd0, ls_req_ready}, 64'd1);
    readTxn(64'h300, 3'd3, 64'h5555, 1'b1, 1'b0);
    checkOutput("waiting ls resp", {62'd0, if_resp_valid, ls_resp_valid}, 64'd1);
    checkOutput("waiting ls data", ls_resp_data, 64'h5555);

    // Reset while in R abandons the read.
    applyStimulus(1'b1, 64'h8000_0080, 1'b0, 1'b0, 3'd0, 64'd0);
    @(negedge clk);
    if_req_valid = 1'b0;
    @(negedge clk);
    checkOutput("pre-reset rready", {63'd0, rready}, 64'd1);
    rst = 1'b1;
    rvalid = 1'b1; rlast = 1'b1; rdata = 64'h6666;
    applyStimulus(1'b1, 64'h8000_0080, 1'b1, 1'b0, 3'd3, 64'h400);
    #1;
    checkOutput("reset outputs", {58'd0, rready, arvalid, if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid}, 64'd0);
    checkOutput("reset clears data", if_resp_data | ls_resp_data, 64'd0);
    @(negedge clk);
    rst = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    #1;
    checkOutput("no resp after reset", {62'd0, if_resp_valid, ls_resp_valid}, 64'd0);
    checkOutput("pointer reset to ls", {62'd0, if_req_ready, ls_req_ready}, 64'd1);
    ls_req_valid = 1'b0;
    #1 checkOutput("post-reset if ready", {63'd0, if_req_ready}, 64'd1);
    readTxn(64'h8000_0080, 3'd2, 64'h7777, 1'b0, 1'b1);
    checkOutput("post-reset resp", {62'd0, if_resp_valid, ls_resp_valid}, 64'd2);
    checkOutput("post-reset data", if_resp_data, 64'h7777);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
